restoring_div16: RTL and testbench

RESTORING_DIV16 -- requirements
Module: restoring_div16

---
 rtl/restoring_div16.sv | 126 ++++++++++++
 tb/tb_restoring_div16.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/restoring_div16.sv
// Restoring unsigned divider: one quotient bit per clock, WIDTH cycles per
// operation, plus a one-cycle DONE state that pulses done with the results.
// A zero divisor short-circuits straight to DONE with a saturated quotient.
module restoring_div16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH:0]   a_q;        // partial remainder, one guard bit for the sign of the trial subtract
    logic [WIDTH-1:0] q_q;        // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] m_q;        // latched divisor
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_q;

    logic [WIDTH:0]   a_sh;
    logic [WIDTH:0]   t_d;
    logic [WIDTH:0]   a_d;
    logic [WIDTH-1:0] q_d;
    logic             last_step;
    logic             accept;

    // One restoring step: shift {A,Q}, trial-subtract M, keep the difference
    // only if it did not go negative.
    always_comb begin
        a_sh = (a_q << 1) | {{WIDTH{1'b0}}, q_q[WIDTH-1]};
        t_d  = a_sh - {1'b0, m_q};
        a_d  = a_sh;
        q_d  = {q_q[WIDTH-2:0], 1'b0};
        if (!t_d[WIDTH]) begin
            a_d    = t_d;
            q_d[0] = 1'b1;
        end
    end

    assign last_step = (cnt_q == CW'(WIDTH - 1));
    // DONE accepts a new request exactly like IDLE so operations can run back to back.
    assign accept    = start && (state_q == S_IDLE || state_q == S_DONE);

    // Controller FSM with registered busy/done and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (state_q == S_DONE) state_q <= S_IDLE;
                    if (accept) begin
                        if (divisor == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            quot_q  <= '1;
                            rem_q   <= dividend;
                            dbz_q   <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            a_q     <= '0;
                            q_q     <= dividend;
                            m_q     <= divisor;
                            cnt_q   <= '0;
                        end
                    end
                end
                S_RUN: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_step) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quot_q  <= q_d;
                        rem_q   <= a_d[WIDTH-1:0];
                        dbz_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_div16.sv
// Directed bench for restoring_div16: reset, latency, zero divisor,
// back-to-back, ignored start, reset abort, and an operand sweep.
module tb_restoring_div16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    restoring_div16 #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one operation and wait (bounded) for done. lat counts edges
    // including the sampling edge; bcyc counts cycles seen with busy=1.
    task automatic do_op(input logic [15:0] dd, input logic [15:0] dv,
                         output int lat, output int bcyc);
        dividend = dd; divisor = dv; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1; bcyc = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcyc++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; dividend = 16'd100; divisor = 16'd7;
        tick(); tick();
        start = 1'b0;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h z=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_basic();
        int lat, bcyc;
        rst = 1'b0;   // start goes on the very first edge with rst low
        do_op(16'd100, 16'd7, lat, bcyc);
        checks++;
        if (lat != 17) begin errors++; $display("FAIL basic_latency: got %0d want 17", lat); end
        checks++;
        if (bcyc != 16) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 16", bcyc); end
        checks++;
        if (quotient !== 16'd14 || remainder !== 16'd2 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got q=%0d r=%0d z=%b want q=14 r=2 z=0", quotient, remainder, div_by_zero);
        end
        tick();
        checks++;
        if (done !== 1'b0 || quotient !== 16'd14) begin
            errors++;
            $display("FAIL basic_done_pulse: got done=%b q=%0d want done=0 q=14", done, quotient);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcyc;
        do_op(16'hFFFF, 16'h0001, lat, bcyc);
        checks++;
        if (lat != 17 || quotient !== 16'hFFFF || remainder !== 16'h0000) begin
            errors++;
            $display("FAIL max_div1: got lat=%0d q=%h r=%h want lat=17 q=ffff r=0000", lat, quotient, remainder);
        end
        // still in DONE here: this start must be accepted immediately
        do_op(16'd3, 16'd10, lat, bcyc);
        checks++;
        if (lat != 17 || quotient !== 16'd0 || remainder !== 16'd3) begin
            errors++;
            $display("FAIL b2b_3_10: got lat=%0d q=%0d r=%0d want lat=17 q=0 r=3", lat, quotient, remainder);
        end
        tick();
    endtask

    task automatic test_div_zero();
        int lat, bcyc;
        do_op(16'd5, 16'd0, lat, bcyc);
        checks++;
        if (lat != 1 || bcyc != 0) begin
            errors++;
            $display("FAIL dz_latency: got lat=%0d busy_cycles=%0d want 1 and 0", lat, bcyc);
        end
        checks++;
        if (quotient !== 16'hFFFF || remainder !== 16'd5 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dz_result: got q=%h r=%0d z=%b want q=ffff r=5 z=1", quotient, remainder, div_by_zero);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dz_hold: got done=%b busy=%b z=%b want 0 0 1", done, busy, div_by_zero);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        repeat (4) begin tick(); lat++; end
        // cycle 5 of RUN: a second request with new operands
        start = 1'b1; dividend = 16'd9; divisor = 16'd9;
        tick(); lat++;
        start = 1'b0; dividend = 16'h1234; divisor = 16'h0002;
        checks++;
        if (busy !== 1'b1 || quotient !== 16'hFFFF || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL ign_midrun: got busy=%b q=%h z=%b want 1 ffff 1", busy, quotient, div_by_zero);
        end
        while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
        checks++;
        if (lat != 17 || quotient !== 16'd333 || remainder !== 16'd1 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL ign_result: got lat=%0d q=%0d r=%0d z=%b want 17 333 1 0", lat, quotient, remainder, div_by_zero);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ign_no_second: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bcyc, seen;
        dividend = 16'hABCD; divisor = 16'h0012; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 35'd0) begin
            errors++;
            $display("FAIL abort_outputs: got busy=%b done=%b q=%h r=%h z=%b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        seen = 0;
        repeat (20) begin tick(); if (done !== 1'b0 || busy !== 1'b0) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen); end
        do_op(16'd20, 16'd6, lat, bcyc);
        checks++;
        if (lat != 17 || quotient !== 16'd3 || remainder !== 16'd2) begin
            errors++;
            $display("FAIL abort_next: got lat=%0d q=%0d r=%0d want 17 3 2", lat, quotient, remainder);
        end
        tick();
    endtask

    task automatic test_sweep();
        logic [15:0] dd [12];
        logic [15:0] dv [12];
        int lat, bcyc;
        dd = '{16'd0, 16'd1, 16'd12345, 16'd7, 16'hFFFF, 16'h8000,
               16'd50000, 16'd0, 16'd65534, 16'd999, 16'd0, 16'd0};
        dv = '{16'd1, 16'd1, 16'd1, 16'd200, 16'hFFFF, 16'h7FFF,
               16'd123, 16'd9, 16'd2, 16'd1000, 16'd0, 16'd0};
        for (int k = 10; k < 12; k++) begin
            dd[k] = 16'($urandom);
            dv[k] = 16'($urandom_range(1, 65535));
        end
        for (int k = 0; k < 12; k++) begin
            do_op(dd[k], dv[k], lat, bcyc);
            checks++;
            if (lat != 17 || quotient !== dd[k] / dv[k] || remainder !== dd[k] % dv[k] ||
                32'(quotient) * 32'(dv[k]) + 32'(remainder) != 32'(dd[k]) || remainder >= dv[k]) begin
                errors++;
                $display("FAIL sweep_%0d: %0d/%0d got lat=%0d q=%0d r=%0d want lat=17 q=%0d r=%0d",
                         k, dd[k], dv[k], lat, quotient, remainder, dd[k] / dv[k], dd[k] % dv[k]);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_ignore_start();
        test_reset_abort();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
